// File: rtl/elevator_pkg.sv
// Shared state encoding and helpers for the N-floor elevator controller.
package elevator_pkg;

  localparam int unsigned MAX_FLOORS = 32;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t MOVING    = 2'd1;
  localparam state_t DOOR_OPEN = 2'd2;

  // One-hot vector of MAX_FLOORS bits with bit idx set; callers truncate to FLOORS.
  function automatic logic [MAX_FLOORS-1:0] onehot(input int unsigned idx);
    onehot = MAX_FLOORS'(1) << idx;
  endfunction

endpackage

// File: rtl/elevator_ctrl_n_tick_timer.sv
// Prescaled tick timer: raises done on the tick that completes `count` ticks.
module tick_timer #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned COUNT_W  = 2
) (
  input  logic               clk_50,
  input  logic               rst,
  input  logic               clear,
  input  logic [COUNT_W-1:0] count,
  output logic               done
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0]   pre;
  logic [COUNT_W-1:0] cnt;
  logic               tick;

  assign tick = (pre == PRE_W'(TICK_DIV - 1));
  assign done = tick && (cnt == count - COUNT_W'(1));

  always_ff @(posedge clk_50) begin
    if (rst || clear) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= tick ? '0 : pre + PRE_W'(1);
      if (tick) cnt <= done ? '0 : cnt + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/elevator_ctrl_n.sv
// N-floor elevator controller: latches calls and serves them in SCAN order.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS       = 3,
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned TRAVEL_TICKS = 3,
  parameter int unsigned DOOR_TICKS   = 2
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic [FLOORS-1:0] call_req,
  output logic [FLOORS-1:0] floor,
  output logic              door,
  output logic              moving,
  output logic              dir_up,
  output logic [FLOORS-1:0] pending
);

  localparam int unsigned FLOOR_W = (FLOORS > 1) ? $clog2(FLOORS) : 1;
  localparam int unsigned MAX_T   = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int unsigned CNT_W   = $clog2(MAX_T + 1);

  state_t             state, state_next;
  logic [FLOOR_W-1:0] cur, cur_next, cur_step;
  logic               dir_next, restart, timer_clear, done;
  logic [FLOORS-1:0]  req, clr, cur_next_oh;
  logic [CNT_W-1:0]   count;

  function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] idx);
    any_above = 1'b0;
    for (int i = 0; i < int'(FLOORS); i++)
      if (i > int'(idx)) any_above = any_above | p[i];
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] idx);
    any_below = 1'b0;
    for (int i = 0; i < int'(FLOORS); i++)
      if (i < int'(idx)) any_below = any_below | p[i];
  endfunction

  assign count = (state == DOOR_OPEN) ? CNT_W'(DOOR_TICKS) : CNT_W'(TRAVEL_TICKS);

  tick_timer #(.TICK_DIV(TICK_DIV), .COUNT_W(CNT_W)) u_timer (
    .clk_50 (clk_50),
    .rst    (rst),
    .clear  (timer_clear),
    .count  (count),
    .done   (done)
  );

  // Next state, SCAN direction and request clear for the current edge.
  always_comb begin
    state_next = state;
    cur_next   = cur;
    dir_next   = dir_up;
    restart    = 1'b0;
    req        = pending | call_req;
    cur_step   = dir_up ? cur + FLOOR_W'(1) : cur - FLOOR_W'(1);
    case (state)
      IDLE: begin
        if (pending[cur]) begin
          state_next = DOOR_OPEN;
        end else if (any_above(pending, cur) && (dir_up || !any_below(pending, cur))) begin
          dir_next   = 1'b1;
          state_next = MOVING;
        end else if (any_below(pending, cur)) begin
          dir_next   = 1'b0;
          state_next = MOVING;
        end
      end
      MOVING: begin
        if (done) begin
          cur_next = cur_step;
          if (req[cur_step])
            state_next = DOOR_OPEN;
          else if (!(dir_up ? any_above(pending, cur_step) : any_below(pending, cur_step)))
            state_next = IDLE;
        end
      end
      DOOR_OPEN: begin
        if (call_req[cur]) restart = 1'b1;
        else if (done)     state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    cur_next_oh = FLOORS'(onehot(32'(cur_next)));
    clr         = ((state == DOOR_OPEN) || (state_next == DOOR_OPEN)) ? cur_next_oh : '0;
    timer_clear = (state_next != state) || ((state == MOVING) && done) || restart;
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state   <= IDLE;
      cur     <= '0;
      dir_up  <= 1'b1;
      pending <= '0;
      floor   <= FLOORS'(1);
      door    <= 1'b0;
      moving  <= 1'b0;
    end else begin
      state   <= state_next;
      cur     <= cur_next;
      dir_up  <= dir_next;
      pending <= req & ~clr;
      floor   <= cur_next_oh;
      door    <= (state_next == DOOR_OPEN);
      moving  <= (state_next == MOVING);
    end
  end

endmodule
